// File: rtl/lane_alu_engine.sv
// Multi-lane vector ALU behind a host command port; one lane per RUN cycle.
// Ports: clock/reset, req_* command (always ready), rsp_* registered response, busy/done status.
module lane_alu_engine #(
    parameter int LANES = 4,
    parameter int WIDTH = 32,
    localparam int AW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_id,
    input  logic [AW-1:0]    req_addr,
    input  logic [WIDTH-1:0] req_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_START = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ID_CC = 2'd0,
        ID_RA = 2'd1,
        ID_RB = 2'd2,
        ID_RY = 2'd3
    } id_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [AW:0]   LANES_W = (AW+1)'(LANES);
    localparam logic [AW-1:0] LAST    = AW'(LANES - 1);

    state_e state, state_n;

    logic [WIDTH-1:0] ra [LANES];
    logic [WIDTH-1:0] rb [LANES];
    logic [WIDTH-1:0] ry [LANES];
    logic [31:0]      cc;
    logic [1:0]       mode;
    logic             sat;
    logic [AW-1:0]    idx;

    logic             addr_bad;
    logic             req_err;
    logic             start_ok;
    logic             wr_ok;
    logic             rd_ok;
    logic [WIDTH-1:0] rd_data;

    // Signed add/sub evaluated one bit wider so overflow is the
    // disagreement of the top two bits; the top bit is the true sign.
    function automatic logic [WIDTH-1:0] lane_f(
        input logic [1:0]       m,
        input logic             s,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   x;
        logic [WIDTH-1:0] r;
        x = '0;
        r = '0;
        case (m)
            2'd0: x = {a[WIDTH-1], a} + {b[WIDTH-1], b};
            2'd1: x = {a[WIDTH-1], a} - {b[WIDTH-1], b};
            default: x = '0;
        endcase
        case (m)
            2'd0, 2'd1: begin
                if (s && (x[WIDTH] ^ x[WIDTH-1]))
                    r = x[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
                else
                    r = x[WIDTH-1:0];
            end
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign req_ready = 1'b1;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

    always_comb begin
        addr_bad = (req_id != ID_CC) && ({1'b0, req_addr} >= LANES_W);
        req_err  = 1'b0;
        case (req_op)
            OP_WRITE: req_err = busy || (req_id == ID_RY) || addr_bad;
            OP_READ:  req_err = addr_bad;
            OP_START: req_err = busy;
            default:  req_err = 1'b0;
        endcase
        start_ok = req_valid && (req_op == OP_START) && !req_err;
        wr_ok    = req_valid && (req_op == OP_WRITE) && !req_err;
        rd_ok    = req_valid && (req_op == OP_READ) && !req_err;
    end

    // Only consumed when rd_ok, so the index is always in range there.
    always_comb begin
        rd_data = '0;
        case (req_id)
            ID_CC:   rd_data = WIDTH'(cc);
            ID_RA:   rd_data = ra[req_addr];
            ID_RB:   rd_data = rb[req_addr];
            default: rd_data = ry[req_addr];
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_ok) state_n = S_RUN;
            S_RUN:   if (idx == LAST) state_n = S_DONE;
            S_DONE:  state_n = start_ok ? S_RUN : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                ra[i] <= '0;
                rb[i] <= '0;
                ry[i] <= '0;
            end
            cc        <= '0;
            mode      <= '0;
            sat       <= 1'b0;
            idx       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= req_valid;
            rsp_err   <= req_valid && req_err;
            rsp_data  <= rd_ok ? rd_data : '0;

            if (wr_ok) begin
                case (req_id)
                    ID_CC:   cc <= 32'(req_data);
                    ID_RA:   ra[req_addr] <= req_data;
                    ID_RB:   rb[req_addr] <= req_data;
                    default: ;
                endcase
            end

            // Writes and START are refused while running, so these
            // never collide with the lane updates below.
            if (start_ok) begin
                mode <= req_data[1:0];
                sat  <= req_data[2];
                cc   <= '0;
                idx  <= '0;
            end else if (state == S_RUN) begin
                ry[idx] <= lane_f(mode, sat, ra[idx], rb[idx]);
                cc      <= cc + 32'd1;
                idx     <= idx + AW'(1);
            end
        end
    end

endmodule
